// File: rtl/pipe_divider_pkg.sv
// Shared types for the pipelined divider.
// Stage record and latency helper.
package pipe_divider_pkg;

  localparam int DVD_W = 26;
  localparam int DVS_W = 14;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic             valid;
    logic [DVS_W-1:0] rem;
    logic [DVD_W-1:0] quo;
    logic [DVD_W-1:0] dvd;
    logic [DVS_W-1:0] dvs;
    logic             q_sign;
    logic             r_sign;
    logic             div_zero;
    logic [TAG_W-1:0] id;
  } stage_t;

  function automatic int lat(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/pipe_divider_stage.sv
// One restoring-division step.
// Produces one quotient bit per cycle.
module pipe_divider_stage
  import pipe_divider_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  logic [DVS_W:0]   p;
  logic [DVS_W-1:0] diff;
  logic             ge;
  stage_t           nxt;

  // Trial subtract of |divisor| from the shifted partial remainder
  always_comb begin
    nxt  = d;
    p    = {d.rem, d.dvd[DVD_W-1]};
    ge   = (p >= {1'b0, d.dvs});
    diff = p[DVS_W-1:0] - d.dvs;
    nxt.rem = ge ? diff : p[DVS_W-1:0];
    nxt.quo = {d.quo[DVD_W-2:0], ge};
    nxt.dvd = {d.dvd[DVD_W-2:0], 1'b0};
  end

  // Stage register, frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= nxt;
  end

endmodule

// File: rtl/pipe_divider.sv
// Fully pipelined signed/unsigned divider.
// One op per cycle, valid/ready with backpressure.
module pipe_divider
  import pipe_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DVD_W,
  parameter int DIVISOR_W  = DVS_W,
  parameter int ID_W       = TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  input  logic                  in_signed,
  input  logic [ID_W-1:0]       in_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic                  out_div_zero,
  output logic [ID_W-1:0]       out_id
);

  logic   en;
  logic   sign_a;
  logic   sign_b;
  stage_t s0_nxt;
  stage_t s0;
  stage_t st [0:DIVIDEND_W];
  stage_t last;

  logic [DIVIDEND_W-1:0] fx_q;
  logic [DIVISOR_W-1:0]  fx_r;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Input stage: magnitudes and result signs
  always_comb begin
    sign_a = in_signed & in_dividend[DIVIDEND_W-1];
    sign_b = in_signed & in_divisor[DIVISOR_W-1];
    s0_nxt          = '0;
    s0_nxt.valid    = in_valid;
    s0_nxt.dvd      = sign_a ? -in_dividend : in_dividend;
    s0_nxt.dvs      = sign_b ? -in_divisor : in_divisor;
    s0_nxt.q_sign   = sign_a ^ sign_b;
    s0_nxt.r_sign   = sign_a;
    s0_nxt.div_zero = (in_divisor == '0);
    s0_nxt.id       = in_id;
  end

  // Input stage register
  always_ff @(posedge clk) begin
    if (rst)
      s0 <= '0;
    else if (en)
      s0 <= s0_nxt;
  end

  assign st[0] = s0;

  for (genvar k = 0; k < DIVIDEND_W; k++) begin : g_stage
    pipe_divider_stage u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (st[k]),
      .q   (st[k+1])
    );
  end

  assign last = st[DIVIDEND_W];

  // Sign fix-up, with divide-by-zero forced independently
  always_comb begin
    fx_q = last.q_sign ? -last.quo : last.quo;
    fx_r = last.r_sign ? -last.rem : last.rem;
    if (last.div_zero) begin
      fx_q = '1;
      fx_r = '0;
    end
  end

  // Output register; data only updates on a real result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_id        <= '0;
    end else if (en) begin
      out_valid <= last.valid;
      if (last.valid) begin
        out_quotient  <= fx_q;
        out_remainder <= fx_r;
        out_div_zero  <= last.div_zero;
        out_id        <= last.id;
      end
    end
  end

endmodule

// File: tb/tb_pipe_divider.sv
// Self-checking bench for pipe_divider.
// Table vectors, random streams, stalls and reset.
module tb_pipe_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] in_dividend = '0;
  logic [13:0] in_divisor = '0;
  logic        in_signed = 1'b0;
  logic [3:0]  in_id = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] out_quotient;
  logic [13:0] out_remainder;
  logic        out_div_zero;
  logic [3:0]  out_id;

  typedef struct packed {
    logic [25:0] q;
    logic [13:0] r;
    logic        dz;
    logic [3:0]  id;
  } exp_t;

  typedef struct {
    logic [25:0] a;
    logic [13:0] b;
    logic        s;
    logic [3:0]  id;
    exp_t        e;
  } vec_t;

  exp_t  sb[$];
  exp_t  cur_exp;
  vec_t  tbl[13];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;
  bit    rand_ready = 1'b0;
  bit    have_hold = 1'b0;
  logic [44:0] hold;

  pipe_divider dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .in_signed     (in_signed),
    .in_id         (in_id),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .out_id        (out_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [25:0] a,
                                 input logic [13:0] b,
                                 input logic s,
                                 input logic [3:0] id);
    exp_t   e;
    longint sa, sbv, qq, rr;
    e.id = id;
    if (b == 14'd0) begin
      e.q  = '1;
      e.r  = '0;
      e.dz = 1'b1;
      return e;
    end
    sa  = s ? {{38{a[25]}}, a} : {38'b0, a};
    sbv = s ? {{50{b[13]}}, b} : {50'b0, b};
    qq  = sa / sbv;
    rr  = sa % sbv;
    e.q  = qq[25:0];
    e.r  = rr[13:0];
    e.dz = 1'b0;
    return e;
  endfunction

  // Monitor: stall rule, hold stability, scoreboard push/pop
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      have_hold = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (have_hold)
        chk("held_output",
            {out_valid, out_quotient, out_remainder, out_div_zero, out_id},
            {1'b1, hold});
      if (out_valid && !out_ready) begin
        hold = {out_quotient, out_remainder, out_div_zero, out_id};
        have_hold = 1'b1;
      end else begin
        have_hold = 1'b0;
      end
      if (in_valid && in_ready)
        sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got id %0h q %0h, required none",
                   out_id, out_quotient);
        end else begin
          e = sb.pop_front();
          chk("id", out_id, e.id);
          chk("quotient", out_quotient, e.q);
          chk("remainder", out_remainder, e.r);
          chk("div_zero", out_div_zero, e.dz);
          hs_cnt++;
          if (hs_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [25:0] a, input logic [13:0] b,
                      input logic s, input logic [3:0] id,
                      input exp_t e);
    bit acc;
    int n;
    in_dividend = a;
    in_divisor  = b;
    in_signed   = s;
    in_id       = id;
    cur_exp     = e;
    in_valid    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", n, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_budget", n < 3000, 1);
  endtask

  task automatic send_rand(input int i);
    logic [25:0] a;
    logic [13:0] b;
    logic        s;
    a = 26'($urandom);
    case ($urandom_range(0, 7))
      0:       b = 14'd0;
      1:       b = 14'($urandom_range(1, 15));
      2:       b = 14'h3FFF;
      default: b = 14'($urandom);
    endcase
    if ($urandom_range(0, 15) == 0) a = 26'h2000000;
    s = 1'($urandom_range(0, 1));
    send(a, b, s, 4'(i), model(a, b, s, 4'(i)));
  endtask

  initial begin
    int n;
    tbl[0]  = '{26'd1000, 14'd7, 1'b0, 4'd3, '{26'd142, 14'd6, 1'b0, 4'd3}};
    tbl[1]  = '{26'h3FFFFF9, 14'd2, 1'b1, 4'd1,
                '{26'h3FFFFFD, 14'h3FFF, 1'b0, 4'd1}};
    tbl[2]  = '{26'd7, 14'h3FFE, 1'b1, 4'd2,
                '{26'h3FFFFFD, 14'd1, 1'b0, 4'd2}};
    tbl[3]  = '{26'd12345, 14'd0, 1'b0, 4'd4,
                '{26'h3FFFFFF, 14'd0, 1'b1, 4'd4}};
    tbl[4]  = '{26'd12345, 14'd0, 1'b1, 4'd5,
                '{26'h3FFFFFF, 14'd0, 1'b1, 4'd5}};
    tbl[5]  = '{26'h2000000, 14'h3FFF, 1'b1, 4'd6,
                '{26'h2000000, 14'd0, 1'b0, 4'd6}};
    tbl[6]  = '{26'd100, 14'd3, 1'b0, 4'd7, '{26'd33, 14'd1, 1'b0, 4'd7}};
    tbl[7]  = '{26'd0, 14'd5, 1'b0, 4'd8, '{26'd0, 14'd0, 1'b0, 4'd8}};
    tbl[8]  = '{26'h3FFFFFF, 14'd1, 1'b0, 4'd9,
                '{26'h3FFFFFF, 14'd0, 1'b0, 4'd9}};
    tbl[9]  = '{26'h3FFFFFF, 14'h3FFF, 1'b0, 4'd10,
                '{26'h1000, 14'hFFF, 1'b0, 4'd10}};
    tbl[10] = '{26'd13, 14'h2000, 1'b1, 4'd11,
                '{26'd0, 14'd13, 1'b0, 4'd11}};
    tbl[11] = '{26'h3FFE000, 14'h2000, 1'b1, 4'd12,
                '{26'd1, 14'd0, 1'b0, 4'd12}};
    tbl[12] = '{26'h3FFFF9C, 14'h3FF9, 1'b1, 4'd13,
                '{26'd14, 14'h3FFE, 1'b0, 4'd13}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", out_quotient, 0);
    chk("rst_remainder", out_remainder, 0);
    chk("rst_div_zero", out_div_zero, 0);
    chk("rst_id", out_id, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency of a lone op
    send(26'd1000, 14'd7, 1'b0, 4'd3, '{26'd142, 14'd6, 1'b0, 4'd3});
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 28);
    drain();

    // Directed table, streamed back to back
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].id, tbl[i].e);
    drain();

    // 64 back-to-back random ops at full rate
    hs_cnt = 0;
    for (int i = 0; i < 64; i++) send_rand(i);
    drain();
    chk("b2b_count", hs_cnt, 64);
    chk("b2b_consecutive", last_cyc - first_cyc, 63);

    // Random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) send_rand(i);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with ops in flight
    for (int i = 0; i < 10; i++) send_rand(i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("no_stale_valid", out_valid, 0);
    send(26'd100, 14'd3, 1'b0, 4'd5, '{26'd33, 14'd1, 1'b0, 4'd5});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
